// File: rtl/pipeline_hazard_controller.sv
// Hazard/stall/flush sequencer and operand-forwarding selector for a 5-stage RISC-V pipe.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        ex_rf_enable,
  input  logic        mem_rf_enable,
  input  logic        wb_rf_enable,
  input  logic        ex_load_instr,
  input  logic        ex_redirect,
  input  logic        mem_ram_enable,
  input  logic        ram_ready,
  output logic        pc_load_enable,
  output logic        if_id_load_enable,
  output logic        if_id_flush,
  output logic        cu_mux_select,
  output logic        pipe_hold,
  output logic [1:0]  fwd_a_select,
  output logic [1:0]  fwd_b_select,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycle_count,
  output logic [31:0] redirect_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_FLUSH    = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic       ram_stall;
  logic       load_use;
  logic       redirect_acc;

  assign ram_stall = mem_ram_enable & ~ram_ready;
  assign load_use  = ex_load_instr & ex_rf_enable & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    flush_cnt_d       = flush_cnt_q;
    pc_load_enable    = 1'b1;
    if_id_load_enable = 1'b1;
    if_id_flush       = 1'b0;
    cu_mux_select     = 1'b0;
    pipe_hold         = 1'b0;
    redirect_acc      = 1'b0;
    case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (ram_stall) begin
          // A RAM stall outranks everything and abandons any flush in progress.
          pc_load_enable    = 1'b0;
          if_id_load_enable = 1'b0;
          pipe_hold         = 1'b1;
          state_d           = ST_MEM_WAIT;
          flush_cnt_d       = 4'd0;
        end else if (ex_redirect) begin
          if_id_flush   = 1'b1;
          cu_mux_select = 1'b1;
          redirect_acc  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end else begin
            state_d     = ST_RUN;
            flush_cnt_d = 4'd0;
          end
        end else if (state_q == ST_FLUSH) begin
          if_id_flush   = 1'b1;
          cu_mux_select = 1'b1;
          flush_cnt_d   = flush_cnt_q - 4'd1;
          if (flush_cnt_q <= 4'd1) state_d = ST_RUN;
        end else if (load_use) begin
          pc_load_enable    = 1'b0;
          if_id_load_enable = 1'b0;
          cu_mux_select     = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!ram_ready) begin
          pc_load_enable    = 1'b0;
          if_id_load_enable = 1'b0;
          pipe_hold         = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = 4'd0;
      end
    endcase
    // Reset forces the free-running outputs regardless of what the pipe presents.
    if (!reset_n) begin
      pc_load_enable    = 1'b1;
      if_id_load_enable = 1'b1;
      if_id_flush       = 1'b0;
      cu_mux_select     = 1'b0;
      pipe_hold         = 1'b0;
      redirect_acc      = 1'b0;
    end
  end

  assign ctrl_state = state_q;

  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (r != 5'd0) begin
      if (ex_rf_enable && !ex_load_instr && (ex_rd == r)) sel = 2'b01;
      else if (mem_rf_enable && (mem_rd == r))             sel = 2'b10;
      else if (wb_rf_enable && (wb_rd == r))               sel = 2'b11;
    end
    return sel;
  endfunction

  assign fwd_a_select = fwd_sel(id_rs1);
  assign fwd_b_select = fwd_sel(id_rs2);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      if (!pc_load_enable) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_acc)    redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign stall_cycle_count = stall_cnt_q;
  assign redirect_count    = redirect_cnt_q;
`else
  logic unused_redirect_acc;
  assign unused_redirect_acc = redirect_acc;
  assign stall_cycle_count   = 32'd0;
  assign redirect_count      = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: vector table, corner sequences, random vs model.
module tb_pipeline_hazard_controller;

  localparam int unsigned FC = 2;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_rf_enable, mem_rf_enable, wb_rf_enable;
  logic ex_load_instr, ex_redirect, mem_ram_enable, ram_ready;
  logic pc_load_enable, if_id_load_enable, if_id_flush, cu_mux_select, pipe_hold;
  logic [1:0] fwd_a_select, fwd_b_select, ctrl_state;
  logic [31:0] stall_cycle_count, redirect_count;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable), .wb_rf_enable(wb_rf_enable),
    .ex_load_instr(ex_load_instr), .ex_redirect(ex_redirect),
    .mem_ram_enable(mem_ram_enable), .ram_ready(ram_ready),
    .pc_load_enable(pc_load_enable), .if_id_load_enable(if_id_load_enable),
    .if_id_flush(if_id_flush), .cu_mux_select(cu_mux_select), .pipe_hold(pipe_hold),
    .fwd_a_select(fwd_a_select), .fwd_b_select(fwd_b_select), .ctrl_state(ctrl_state),
    .stall_cycle_count(stall_cycle_count), .redirect_count(redirect_count)
  );

  typedef struct {
    logic [4:0] rs1, rs2, exr, memr, wbr;
    logic u1, u2, exe, meme, wbe, ld, redir, ram_en, rdy;
  } in_t;

  typedef struct {
    in_t i;
    logic pc, cu;
    logic [1:0] fa, fb;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 run, 1 flushing, 2 waiting on RAM; flush_left = flush cycles still owed.
  int          m_mode, n_mode, m_left, n_left;
  logic [31:0] m_stall, n_stall, m_redir, n_redir;
  logic        e_pc, e_flush, e_cu, e_hold;
  logic [1:0]  e_state;
  logic        o_pc, o_ifid, o_flush, o_cu, o_hold;
  logic [1:0]  o_state, o_fa, o_fb;
  logic [31:0] o_stall, o_redir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{rs1: 0, rs2: 0, exr: 0, memr: 0, wbr: 0, u1: 0, u2: 0, exe: 0, meme: 0,
          wbe: 0, ld: 0, redir: 0, ram_en: 0, rdy: 1};
    return v;
  endfunction

  function automatic in_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                             input logic u2, input logic [4:0] exr, input logic exe,
                             input logic ld, input logic [4:0] memr, input logic meme,
                             input logic [4:0] wbr, input logic wbe);
    in_t v;
    v = idle();
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.exr = exr; v.exe = exe; v.ld = ld;
    v.memr = memr; v.meme = meme; v.wbr = wbr; v.wbe = wbe;
    return v;
  endfunction

  function automatic vec_t mkv(input in_t i, input logic pc, input logic cu,
                               input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.i = i; v.pc = pc; v.cu = cu; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic set_in(input in_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.exr; mem_rd = v.memr; wb_rd = v.wbr;
    ex_rf_enable = v.exe; mem_rf_enable = v.meme; wb_rf_enable = v.wbe;
    ex_load_instr = v.ld; ex_redirect = v.redir; mem_ram_enable = v.ram_en; ram_ready = v.rdy;
  endtask

  // Producers listed youngest first; the first live writer of r wins.
  function automatic logic [1:0] fwd_model(input logic [4:0] r);
    logic [4:0] rd [3];
    logic       ok [3];
    rd[0] = ex_rd;  ok[0] = ex_rf_enable && !ex_load_instr;
    rd[1] = mem_rd; ok[1] = mem_rf_enable;
    rd[2] = wb_rd;  ok[2] = wb_rf_enable;
    if (r == 5'd0) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (ok[k] && rd[k] == r) return 2'(k + 1);
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_stall = 0; m_redir = 0;
  endtask

  task automatic model_eval();
    logic busy, lu, took;
    busy = mem_ram_enable && !ram_ready;
    lu = ex_load_instr && ex_rf_enable && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    e_pc = 1; e_flush = 0; e_cu = 0; e_hold = 0; e_state = 2'(m_mode);
    n_mode = m_mode; n_left = m_left; took = 0;
    if (m_mode == 2) begin
      if (!ram_ready) begin e_pc = 0; e_hold = 1; end
      else n_mode = 0;
    end else if (busy) begin
      e_pc = 0; e_hold = 1; n_mode = 2; n_left = 0;
    end else if (ex_redirect) begin
      e_flush = 1; e_cu = 1; took = 1;
      n_left = FC - 1;
      n_mode = (n_left > 0) ? 1 : 0;
    end else if (m_mode == 1) begin
      e_flush = 1; e_cu = 1;
      n_left = m_left - 1;
      n_mode = (n_left > 0) ? 1 : 0;
    end else if (lu) begin
      e_pc = 0; e_cu = 1;
    end
    n_stall = PERF ? m_stall + 32'(!e_pc) : 32'd0;
    n_redir = PERF ? m_redir + 32'(took) : 32'd0;
  endtask

  // Starts at posedge+1 with inputs applied; samples mid-cycle, then advances one clock.
  task automatic cycle(input string tag);
    #3;
    model_eval();
    o_pc = pc_load_enable; o_ifid = if_id_load_enable; o_flush = if_id_flush;
    o_cu = cu_mux_select; o_hold = pipe_hold; o_state = ctrl_state;
    o_fa = fwd_a_select; o_fb = fwd_b_select; o_stall = stall_cycle_count; o_redir = redirect_count;
    chk({tag, " pc_load"}, o_pc, e_pc);
    chk({tag, " if_id_load"}, o_ifid, e_pc);
    chk({tag, " flush"}, o_flush, e_flush);
    chk({tag, " cu_mux"}, o_cu, e_cu);
    chk({tag, " hold"}, o_hold, e_hold);
    chk({tag, " state"}, o_state, e_state);
    chk({tag, " fwd_a"}, o_fa, fwd_model(id_rs1));
    chk({tag, " fwd_b"}, o_fb, fwd_model(id_rs2));
    chk({tag, " stall_cnt"}, o_stall, m_stall);
    chk({tag, " redir_cnt"}, o_redir, m_redir);
    $display("%s st=%0d pc=%0b fl=%0b cu=%0b hold=%0b fa=%0d fb=%0d stall=%0d redir=%0d",
             tag, o_state, o_pc, o_flush, o_cu, o_hold, o_fa, o_fb, o_stall, o_redir);
    @(posedge clk);
    m_mode = n_mode; m_left = n_left; m_stall = n_stall; m_redir = n_redir;
    #1;
  endtask

  task automatic mid_reset(input string tag, input logic [1:0] pre_state);
    #1 chk({tag, " pre_state"}, ctrl_state, pre_state);
    #1 reset_n = 1'b0;
    #1;
    chk({tag, " state"}, ctrl_state, 2'b00);
    chk({tag, " pc_load"}, pc_load_enable, 1'b1);
    chk({tag, " if_id_load"}, if_id_load_enable, 1'b1);
    chk({tag, " flush"}, if_id_flush, 1'b0);
    chk({tag, " cu_mux"}, cu_mux_select, 1'b0);
    chk({tag, " hold"}, pipe_hold, 1'b0);
    chk({tag, " stall_cnt"}, stall_cycle_count, 32'd0);
    chk({tag, " redir_cnt"}, redirect_count, 32'd0);
    chk({tag, " fwd_a"}, fwd_a_select, fwd_model(id_rs1));
    $display("%s reset asserted st=%0d pc=%0b", tag, ctrl_state, pc_load_enable);
    model_reset();
    set_in(idle());
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    in_t  v;
    logic [31:0] base;

    // Reset with a stall and redirect presented: outputs must still read as RUN-normal.
    reset_n = 1'b0;
    v = mk(3, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    v.ram_en = 1; v.rdy = 0; v.redir = 1;
    set_in(v);
    model_reset();
    #3;
    chk("reset state", ctrl_state, 2'b00);
    chk("reset pc_load", pc_load_enable, 1'b1);
    chk("reset if_id_load", if_id_load_enable, 1'b1);
    chk("reset flush", if_id_flush, 1'b0);
    chk("reset cu_mux", cu_mux_select, 1'b0);
    chk("reset hold", pipe_hold, 1'b0);
    chk("reset fwd_a", fwd_a_select, 2'b10);
    chk("reset stall_cnt", stall_cycle_count, 32'd0);
    chk("reset redir_cnt", redirect_count, 32'd0);
    $display("reset st=%0d pc=%0b hold=%0b fa=%0d", ctrl_state, pc_load_enable, pipe_hold, fwd_a_select);
    @(posedge clk);
    set_in(idle());
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Vectors from RUN; none of them leaves RUN.
    tbl.push_back(mkv(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0), 0, 1, 2'b00, 2'b00)); // load-use rs1
    tbl.push_back(mkv(mk(5, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0), 1, 0, 2'b10, 2'b00)); // load now in MEM
    tbl.push_back(mkv(mk(0, 0, 3, 1, 3, 1, 0, 3, 1, 3, 1), 1, 0, 2'b00, 2'b01)); // EX beats MEM/WB
    tbl.push_back(mkv(mk(0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1), 1, 0, 2'b00, 2'b00)); // x0 never forwarded
    tbl.push_back(mkv(mk(7, 1, 0, 0, 0, 0, 0, 7, 0, 7, 1), 1, 0, 2'b11, 2'b00)); // WB only
    tbl.push_back(mkv(mk(0, 0, 9, 1, 9, 0, 0, 9, 1, 9, 1), 1, 0, 2'b00, 2'b10)); // MEM beats WB
    tbl.push_back(mkv(mk(0, 0, 6, 0, 6, 1, 1, 0, 0, 6, 1), 1, 0, 2'b00, 2'b11)); // rs2 unused, no LU
    tbl.push_back(mkv(mk(0, 0, 6, 1, 6, 1, 1, 0, 0, 0, 0), 0, 1, 2'b00, 2'b00)); // load-use rs2
    tbl.push_back(mkv(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0), 1, 0, 2'b00, 2'b00)); // load to x0
    tbl.push_back(mkv(mk(4, 1, 0, 0, 4, 0, 1, 0, 0, 0, 0), 1, 0, 2'b00, 2'b00)); // load not writing
    foreach (tbl[n]) begin
      set_in(tbl[n].i);
      cycle($sformatf("vec%0d", n));
      chk($sformatf("vec%0d tbl_pc", n), o_pc, tbl[n].pc);
      chk($sformatf("vec%0d tbl_cu", n), o_cu, tbl[n].cu);
      chk($sformatf("vec%0d tbl_fa", n), o_fa, tbl[n].fa);
      chk($sformatf("vec%0d tbl_fb", n), o_fb, tbl[n].fb);
    end

    // Redirect pulse: two flush cycles, state 00 -> 01 -> 00.
    base = m_redir;
    v = idle(); v.redir = 1; set_in(v);
    cycle("redir0");
    chk("redir0 seq_flush", o_flush, 1'b1);
    chk("redir0 seq_state", o_state, 2'b00);
    set_in(idle());
    cycle("redir1");
    chk("redir1 seq_flush", o_flush, 1'b1);
    chk("redir1 seq_state", o_state, 2'b01);
    cycle("redir2");
    chk("redir2 seq_flush", o_flush, 1'b0);
    chk("redir2 seq_state", o_state, 2'b00);
    chk("redir2 seq_count", o_redir, PERF ? base + 32'd1 : 32'd0);

    // RAM busy three cycles with a redirect waiting in EX.
    base = m_stall;
    v = idle(); v.redir = 1; v.ram_en = 1; v.rdy = 0; set_in(v);
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("wait%0d", k));
      chk($sformatf("wait%0d seq_hold", k), o_hold, 1'b1);
      chk($sformatf("wait%0d seq_flush", k), o_flush, 1'b0);
      chk($sformatf("wait%0d seq_state", k), o_state, (k == 0) ? 2'b00 : 2'b10);
    end
    v.rdy = 1; set_in(v);
    cycle("wait3");
    chk("wait3 seq_state", o_state, 2'b10);
    chk("wait3 seq_pc", o_pc, 1'b1);
    chk("wait3 seq_hold", o_hold, 1'b0);
    v.ram_en = 0; set_in(v);
    cycle("wait4");
    chk("wait4 seq_state", o_state, 2'b00);
    chk("wait4 seq_flush", o_flush, 1'b1);
    chk("wait4 seq_stall", o_stall, PERF ? base + 32'd3 : 32'd0);
    set_in(idle());
    cycle("wait5");
    cycle("wait6");

    // Asynchronous reset mid-FLUSH and mid-MEM_WAIT.
    v = idle(); v.redir = 1; set_in(v);
    cycle("pre_rst_flush");
    set_in(idle());
    mid_reset("rst_flush", 2'b01);
    cycle("post_rst_flush");
    v = idle(); v.ram_en = 1; v.rdy = 0; set_in(v);
    cycle("pre_rst_wait");
    mid_reset("rst_wait", 2'b10);
    cycle("post_rst_wait");

    // Random traffic on a small register window so hazards collide often.
    for (int k = 0; k < 400; k++) begin
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.exr = 5'($urandom_range(0, 3)); v.memr = 5'($urandom_range(0, 3));
      v.wbr = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom_range(0, 1)); v.u2 = 1'($urandom_range(0, 1));
      v.exe = 1'($urandom_range(0, 1)); v.meme = 1'($urandom_range(0, 1));
      v.wbe = 1'($urandom_range(0, 1)); v.ld = ($urandom_range(0, 9) < 3);
      v.redir = ($urandom_range(0, 9) < 2); v.ram_en = ($urandom_range(0, 9) < 3);
      v.rdy = ($urandom_range(0, 9) < 6);
      set_in(v);
      cycle($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequences the five-stage RISC-V pipeline around its bubble and forwarding multiplexers. Each cycle it decides whether the PC and IF/ID register load, whether the control-unit multiplexer injects a bubble into ID/EX, whether IF/ID is flushed, and which source each ID-stage operand four-to-one multiplexer selects. It also freezes the whole pipe while the data RAM is busy. Sits beside the ID stage; its inputs are the destination/enable fields already carried in the ID/EX, EX/MEM and MEM/WB registers.

## Interface
- FLUSH_CYCLES, 1: cycles IF/ID is flushed per taken redirect (1..15)
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  operand actually read
- ex_rd, mem_rd, wb_rd  in  5 each  destination of instruction in EX / MEM / WB
- ex_rf_enable, mem_rf_enable, wb_rf_enable  in  1 each  stage will write register file
- ex_load_instr  in  1  instruction in EX is a load
- ex_redirect  in  1  taken branch, JAL or JALR resolved in EX
- mem_ram_enable  in  1  MEM stage accessing RAM
- ram_ready  in  1  RAM completes access this cycle
- pc_load_enable  out  1  PC may update
- if_id_load_enable  out  1  IF/ID may update
- if_id_flush  out  1  IF/ID loads a NOP
- cu_mux_select  out  1  1 = control-unit multiplexer drives bubble
- pipe_hold  out  1  ID/EX, EX/MEM, MEM/WB hold
- fwd_a_select, fwd_b_select  out  2 each  00 regfile, 01 EX result, 10 MEM result, 11 WB data
- ctrl_state  out  2  00 RUN, 01 FLUSH, 10 MEM_WAIT
- stall_cycle_count, redirect_count  out  32 each  performance counters

## Operation
- Load-use hazard (LU): ex_load_instr & ex_rf_enable & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority each cycle: MEM_WAIT condition > redirect > LU.
- RUN:
  - mem_ram_enable & !ram_ready: pc_load_enable=0, if_id_load_enable=0, pipe_hold=1; next MEM_WAIT.
  - else ex_redirect: if_id_flush=1, cu_mux_select=1, pc_load_enable=1; next FLUSH if FLUSH_CYCLES>1 (counter loaded with FLUSH_CYCLES-1), else RUN.
  - else LU: pc_load_enable=0, if_id_load_enable=0, cu_mux_select=1; stay RUN. Stall clears when the load advances.
  - else all enables 1, flush/bubble/hold 0.
- FLUSH: if_id_flush=1, cu_mux_select=1, PC loads; counter decrements; at counter==1 next RUN. A RAM stall in FLUSH goes to MEM_WAIT and abandons the remaining flush. A new ex_redirect reloads the counter.
- MEM_WAIT: all loads 0, pipe_hold=1, no bubble, no flush; on ram_ready next RUN with outputs of that cycle as RUN-normal. A redirect or LU held in EX is re-evaluated in RUN.
- Forwarding, per operand r (rs1→a, rs2→b): r==0 → 00. Else EX match (ex_rf_enable & !ex_load_instr & ex_rd==r) → 01. Else MEM match → 10. Else WB match → 11. Else 00. Forwarding is purely combinational and independent of state.

## Timing
- Control outputs are combinational from state and current inputs. State, flush counter and performance counters are registered on the rising clk edge.
- LU bubble: exactly 1 cycle. Redirect penalty: FLUSH_CYCLES cycles.
- MEM_WAIT latency: exit on the edge after ram_ready is sampled high. Zero extra cycles when ram_ready is high in the access cycle.
- Reset (asynchronous, any time): state RUN, flush counter 0, counters 0. During reset, outputs are pc_load_enable=1, if_id_load_enable=1, if_id_flush=0, cu_mux_select=0, pipe_hold=0, ctrl_state=00; fwd selects per combinational rule.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cycle_count increments each cycle pc_load_enable=0. redirect_count increments on each ex_redirect accepted in RUN/FLUSH. Both wrap modulo 2^32.
- Not defined: both counters tied to 0, no counter flops.

## Test plan
- ex_load_instr=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle pc_load_enable=0, cu_mux_select=1; next cycle (load in MEM, mem_rd=5) fwd_a_select=10.
- ex_rd=3 ALU, mem_rd=3, wb_rd=3, all rf_enable=1, id_rs2=3 → fwd_b_select=01; id_rs2=0 with ex_rd=0 → 00.
- FLUSH_CYCLES=2, ex_redirect pulse → if_id_flush=1 for 2 cycles, ctrl_state 00→01→00, redirect_count +1.
- mem_ram_enable=1, ram_ready low 3 cycles with simultaneous ex_redirect → MEM_WAIT 3 cycles, pipe_hold=1, no flush; flush follows exit; stall_cycle_count +3.
- reset_n low mid-FLUSH and mid-MEM_WAIT → ctrl_state=00 immediately, counters 0, pc_load_enable=1.
